pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the fetch stage. It generalises the plain load/clear PC register into a block that does the following:
- sequential increment by a configurable step;
- branch and call redirection;
- stall hold;
- return via an internal circular return-address stack (RAS).

It drives the instruction-memory address and receives redirect requests from decode/execute.

## Interface
Parameters:
- WIDTH, 32, PC and target width in bits
- STEP, 4, increment added on a sequential advance
- RESET_VECTOR, 0, PC value after clr
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- clr  in  1  reset, synchronous, active-high
- stall  in  1  hold PC and RAS unchanged this cycle
- branch_en  in  1  redirect PC to branch_target
- call_en  in  1  redirect to branch_target and push return address
- ret_en  in  1  redirect to popped RAS top
- branch_target  in  WIDTH  redirect target for branch/call
- pc_out  out  WIDTH  current PC (registered)
- ras_empty  out  1  RAS holds 0 entries
- ras_full  out  1  RAS holds RAS_DEPTH entries
- ras_overflow  out  1  one-cycle pulse: push dropped the oldest entry
- ras_underflow  out  1  one-cycle pulse: ret requested with RAS empty

## Operation
- Priority per cycle (highest first): clr, stall, ret_en, call_en, branch_en, sequential.
  - clr: pc_out=RESET_VECTOR, RAS count=0, top pointer=0, ras_overflow=ras_underflow=0. RAS entry contents are don't-care.
  - stall: pc_out, RAS, and count hold. Lower-priority requests in the same cycle are discarded; the requester must re-assert them. Pulse flags are 0.
  - ret_en, RAS not empty: pc_out ← RAS top, pop (count−1).
  - ret_en, RAS empty: treated as sequential. pc_out ← pc_out+STEP, ras_underflow=1 next cycle.
  - call_en (ret_en=0): push pc_out+STEP, then pc_out ← branch_target.
    - If count=RAS_DEPTH, the push overwrites the oldest entry (circular), count stays RAS_DEPTH, and ras_overflow=1 next cycle.
  - branch_en (call_en=ret_en=0): pc_out ← branch_target. RAS unchanged.
  - none: pc_out ← pc_out+STEP.
- Simultaneous rules:
  - call_en+branch_en: behaves as call.
  - ret_en+call_en: behaves as ret; the call is dropped.
- Arithmetic: all PC additions are modulo 2^WIDTH. Wrap from 2^WIDTH−STEP to 0 is legal and silent. Return addresses wrap the same way.
- RAS: circular buffer with a top pointer of log2(RAS_DEPTH) bits.
  - Push: pointer+1 mod depth, then write.
  - Pop: read, then pointer−1 mod depth.
  - Count saturates at RAS_DEPTH and at 0.
- ras_empty = (count==0); ras_full = (count==RAS_DEPTH). Both are registered-state derived, valid every cycle.

## Timing
- All outputs come from registers or from registered state only. There is no combinational path from inputs to outputs.
- Latency: a request sampled on edge N is visible on pc_out after edge N. This is a 1-cycle redirect latency, with no bubble inserted by this block.
- ras_overflow/ras_underflow are high for exactly the one cycle following the offending edge. Back-to-back offences give back-to-back pulses.
- Reset values: pc_out=RESET_VECTOR, ras_empty=1, ras_full=0, ras_overflow=0, ras_underflow=0.
- clr asserted mid-call or mid-stall takes effect on that edge. The RAS is emptied and any concurrent request is discarded.
- clr held for several cycles holds reset values. The first advance happens on the edge after clr deasserts.

## Structure
- Package pc_pkg holds:
  - the pc_op_e enum {PC_HOLD, PC_SEQ, PC_BRANCH, PC_CALL, PC_RET};
  - the priority-decode function;
  - a default STEP constant.
- Sub-module ras_stack holds:
  - parameters WIDTH, RAS_DEPTH;
  - ports clk, clr, push, pop, push_data, top_data, empty, full, overflow, underflow;
  - the circular storage, pointer, and saturating count.
- The pc_unit top holds the decode, the PC register, and the next-PC mux.

## Test plan
(WIDTH=32, STEP=4, RAS_DEPTH=4, RESET_VECTOR=0x0 unless stated.)
1. Reset and sequential: clr=1 for 2 cycles, then idle 3 cycles.
   - During clr: pc_out=0x0.
   - After release: 0x4, 0x8, 0xC.
   - ras_empty=1 throughout.
2. Branch and stall: at pc_out=0x8, branch_en with target 0x100 → pc_out=0x100. Then stall for 2 cycles with branch_en held to 0x200 → pc_out stays 0x100, then 0x104 after release.
3. Call/return: at pc_out=0x10, call_en with target 0x400 → pc_out=0x400, ras_empty=0. Two idle cycles → 0x408. ret_en → pc_out=0x14, ras_empty=1.
4. Overflow: 5 consecutive calls from pc_out=0x0 to targets 0x100, 0x200, 0x300, 0x400, 0x500.
   - After the 4th call: ras_full=1.
   - One-cycle ras_overflow pulse after the 5th call.
   - 4 rets then return 0x404, 0x304, 0x204, 0x104.
   - ras_empty=1.
5. Underflow, wrap, and priority:
   - ret_en on an empty RAS at pc_out=0x20 → pc_out=0x24 and a one-cycle ras_underflow pulse.
   - Separately, RESET_VECTOR=0xFFFFFFFC, release clr → pc_out=0x0.
   - Separately, call_en+ret_en together with one stacked entry → behaves as ret only.
6. Reset mid-operation: 2 entries on the stack, assert clr simultaneously with call_en → pc_out=0x0, ras_empty=1, no overflow pulse. The next ret raises underflow.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage program-counter unit:
// operation encoding, request priority decode and the default increment.
package pc_pkg;

    localparam int unsigned DEFAULT_STEP = 4;

    typedef enum logic [2:0] {
        PC_HOLD,
        PC_SEQ,
        PC_BRANCH,
        PC_CALL,
        PC_RET
    } pc_op_e;

    // clr is handled directly by the registers, so it is not part of the decode
    function automatic pc_op_e pc_decode(
        input logic stall,
        input logic ret_en,
        input logic call_en,
        input logic branch_en
    );
        pc_op_e op;
        op = PC_SEQ;
        if (stall) begin
            op = PC_HOLD;
        end else if (ret_en) begin
            op = PC_RET;
        end else if (call_en) begin
            op = PC_CALL;
        end else if (branch_en) begin
            op = PC_BRANCH;
        end
        return op;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: a push past full silently replaces the oldest
// entry, a pop on empty leaves state untouched; both offences pulse a flag.
module ras_stack #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

    logic [PW-1:0]    ptr_reg, ptr_next;
    logic [CW-1:0]    count_reg, count_next;
    logic             overflow_reg, underflow_reg;
    logic             do_push, do_pop;
    logic [WIDTH-1:0] entry_q [RAS_DEPTH];

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == DEPTH_C);
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

    // pop takes precedence if both ever arrive together
    assign do_push = push && !pop;
    assign do_pop  = pop && !empty;

    always_comb begin
        ptr_next   = ptr_reg;
        count_next = count_reg;
        if (do_push) begin
            ptr_next = ptr_reg + 1'b1;
            if (!full) begin
                count_next = count_reg + 1'b1;
            end
        end else if (do_pop) begin
            ptr_next   = ptr_reg - 1'b1;
            count_next = count_reg - 1'b1;
        end
    end

    // entries carry no reset: their contents are meaningless until pushed
    generate
        for (genvar gi = 0; gi < RAS_DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] entry_reg;
            always_ff @(posedge clk) begin
                if (do_push && (ptr_next == PW'(gi))) begin
                    entry_reg <= push_data;
                end
            end
            assign entry_q[gi] = entry_reg;
        end
    endgenerate

    assign top_data = entry_q[ptr_reg];

    always_ff @(posedge clk) begin
        if (clr) begin
            ptr_reg       <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            ptr_reg       <= ptr_next;
            count_reg     <= count_next;
            overflow_reg  <= do_push && full;
            underflow_reg <= pop && empty;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: sequential advance, branch/call redirect,
// stall hold and return through the internal return-address stack.
module pc_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter int unsigned      STEP         = DEFAULT_STEP,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             stall,
    input  logic             branch_en,
    input  logic             call_en,
    input  logic             ret_en,
    input  logic [WIDTH-1:0] branch_target,
    output logic [WIDTH-1:0] pc_out,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_overflow,
    output logic             ras_underflow
);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    pc_op_e           op;
    logic [WIDTH-1:0] pc_reg, pc_next;
    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] ras_top;
    logic             push, pop;

    assign op     = pc_decode(stall, ret_en, call_en, branch_en);
    assign seq_pc = pc_reg + STEP_W;
    assign push   = (op == PC_CALL);
    assign pop    = (op == PC_RET);
    assign pc_out = pc_reg;

    ras_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .clr       (clr),
        .push      (push),
        .pop       (pop),
        .push_data (seq_pc),
        .top_data  (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .overflow  (ras_overflow),
        .underflow (ras_underflow)
    );

    always_comb begin
        pc_next = seq_pc;
        case (op)
            PC_HOLD:           pc_next = pc_reg;
            PC_SEQ:            pc_next = seq_pc;
            PC_BRANCH, PC_CALL: pc_next = branch_target;
            // a return with nothing stacked degrades to a plain advance
            PC_RET:            pc_next = ras_empty ? seq_pc : ras_top;
            default:           pc_next = seq_pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            pc_reg <= RESET_VECTOR;
        end else begin
            pc_reg <= pc_next;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: a queue-based reference model predicts every
// cycle, and each scenario also carries the literal PC values it must produce.
module tb_pc_unit;
    localparam int W = 32;
    localparam logic [31:0] STEP_C = 32'd4;
    localparam int DEPTH_C = 4;

    logic          clk = 1'b0;
    logic          clr = 1'b0, stall = 1'b0, branch_en = 1'b0, call_en = 1'b0, ret_en = 1'b0;
    logic [W-1:0]  branch_target = '0;
    logic [W-1:0]  pc_out;
    logic          ras_empty, ras_full, ras_overflow, ras_underflow;

    logic          clr_w = 1'b0;
    logic [W-1:0]  pc_w;
    logic          empty_w, full_w, ovf_w, unf_w;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        c, s, r, ca, b;
        logic [31:0] tgt;
        logic [31:0] pc;
    } stim_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  flags;   // {empty, full, overflow, underflow}
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_stack[$];

    always #5 clk = ~clk;

    pc_unit #(.WIDTH(32), .STEP(4), .RESET_VECTOR(32'h0), .RAS_DEPTH(4)) u_dut (
        .clk(clk), .clr(clr), .stall(stall), .branch_en(branch_en), .call_en(call_en),
        .ret_en(ret_en), .branch_target(branch_target), .pc_out(pc_out),
        .ras_empty(ras_empty), .ras_full(ras_full), .ras_overflow(ras_overflow),
        .ras_underflow(ras_underflow)
    );

    pc_unit #(.WIDTH(32), .STEP(4), .RESET_VECTOR(32'hFFFF_FFFC), .RAS_DEPTH(4)) u_dut_wrap (
        .clk(clk), .clr(clr_w), .stall(1'b0), .branch_en(1'b0), .call_en(1'b0),
        .ret_en(1'b0), .branch_target(32'h0), .pc_out(pc_w),
        .ras_empty(empty_w), .ras_full(full_w), .ras_overflow(ovf_w),
        .ras_underflow(unf_w)
    );

    // Drive one cycle, advance the reference model, queue its prediction.
    task automatic drive_cycle(input stim_t st);
        exp_t e;
        logic ovf, unf;
        ovf = 1'b0;
        unf = 1'b0;
        @(negedge clk);
        clr = st.c; stall = st.s; ret_en = st.r; call_en = st.ca; branch_en = st.b;
        branch_target = st.tgt;
        if (st.c) begin
            m_pc = 32'h0;
            m_stack.delete();
        end else if (st.s) begin
            m_pc = m_pc;
        end else if (st.r) begin
            if (m_stack.size() > 0) m_pc = m_stack.pop_back();
            else begin m_pc = m_pc + STEP_C; unf = 1'b1; end
        end else if (st.ca) begin
            if (m_stack.size() == DEPTH_C) begin
                void'(m_stack.pop_front());
                ovf = 1'b1;
            end
            m_stack.push_back(m_pc + STEP_C);
            m_pc = st.tgt;
        end else if (st.b) begin
            m_pc = st.tgt;
        end else begin
            m_pc = m_pc + STEP_C;
        end
        e.pc    = m_pc;
        e.flags = {m_stack.size() == 0, m_stack.size() == DEPTH_C, ovf, unf};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stim_t tbl [5] = '{
            '{1'b1,1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h0},
            '{1'b1,1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h0},
            '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h4},
            '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h8},
            '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0, 32'hC}};
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            drive_cycle(tbl[i]);
            e = exp_q.pop_front();
            $display("[reset] cyc %0d pc=%h flags=%b", i, pc_out,
                     {ras_empty, ras_full, ras_overflow, ras_underflow});
            checks++;
            if (pc_out !== tbl[i].pc) begin errors++;
                $display("FAIL reset_pc cyc %0d: got %h expected %h", i, pc_out, tbl[i].pc); end
            checks++;
            if (pc_out !== e.pc) begin errors++;
                $display("FAIL reset_model_pc cyc %0d: got %h expected %h", i, pc_out, e.pc); end
            checks++;
            if ({ras_empty, ras_full, ras_overflow, ras_underflow} !== e.flags) begin errors++;
                $display("FAIL reset_flags cyc %0d: got %b expected %b", i,
                         {ras_empty, ras_full, ras_overflow, ras_underflow}, e.flags); end
        end
    endtask

    task automatic test_branch_stall();
        stim_t tbl [7] = '{
            '{1'b1,1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h0},
            '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h4},
            '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h8},
            '{1'b0,1'b0,1'b0,1'b0,1'b1, 32'h100, 32'h100},
            '{1'b0,1'b1,1'b0,1'b0,1'b1, 32'h200, 32'h100},
            '{1'b0,1'b1,1'b1,1'b1,1'b1, 32'h200, 32'h100},
            '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h104}};
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            drive_cycle(tbl[i]);
            e = exp_q.pop_front();
            $display("[branch_stall] cyc %0d pc=%h flags=%b", i, pc_out,
                     {ras_empty, ras_full, ras_overflow, ras_underflow});
            checks++;
            if (pc_out !== tbl[i].pc) begin errors++;
                $display("FAIL branch_stall_pc cyc %0d: got %h expected %h", i, pc_out, tbl[i].pc); end
            checks++;
            if ({ras_empty, ras_full, ras_overflow, ras_underflow} !== e.flags) begin errors++;
                $display("FAIL branch_stall_flags cyc %0d: got %b expected %b", i,
                         {ras_empty, ras_full, ras_overflow, ras_underflow}, e.flags); end
        end
    endtask

    task automatic test_call_ret();
        stim_t tbl [9] = '{
            '{1'b1,1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h0},
            '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h4},
            '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h8},
            '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,   32'hC},
            '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h10},
            '{1'b0,1'b0,1'b0,1'b1,1'b0, 32'h400, 32'h400},
            '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h404},
            '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h408},
            '{1'b0,1'b0,1'b1,1'b0,1'b0, 32'h0,   32'h14}};
        exp_t e;
        for (int i = 0; i < 9; i++) begin
            drive_cycle(tbl[i]);
            e = exp_q.pop_front();
            $display("[call_ret] cyc %0d pc=%h flags=%b", i, pc_out,
                     {ras_empty, ras_full, ras_overflow, ras_underflow});
            checks++;
            if (pc_out !== tbl[i].pc) begin errors++;
                $display("FAIL call_ret_pc cyc %0d: got %h expected %h", i, pc_out, tbl[i].pc); end
            checks++;
            if ({ras_empty, ras_full, ras_overflow, ras_underflow} !== e.flags) begin errors++;
                $display("FAIL call_ret_flags cyc %0d: got %b expected %b", i,
                         {ras_empty, ras_full, ras_overflow, ras_underflow}, e.flags); end
        end
    endtask

    task automatic test_overflow();
        stim_t tbl [10] = '{
            '{1'b1,1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h0},
            '{1'b0,1'b0,1'b0,1'b1,1'b0, 32'h100, 32'h100},
            '{1'b0,1'b0,1'b0,1'b1,1'b0, 32'h200, 32'h200},
            '{1'b0,1'b0,1'b0,1'b1,1'b0, 32'h300, 32'h300},
            '{1'b0,1'b0,1'b0,1'b1,1'b0, 32'h400, 32'h400},
            '{1'b0,1'b0,1'b0,1'b1,1'b0, 32'h500, 32'h500},
            '{1'b0,1'b0,1'b1,1'b0,1'b0, 32'h0,   32'h404},
            '{1'b0,1'b0,1'b1,1'b0,1'b0, 32'h0,   32'h304},
            '{1'b0,1'b0,1'b1,1'b0,1'b0, 32'h0,   32'h204},
            '{1'b0,1'b0,1'b1,1'b0,1'b0, 32'h0,   32'h104}};
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            drive_cycle(tbl[i]);
            e = exp_q.pop_front();
            $display("[overflow] cyc %0d pc=%h flags=%b", i, pc_out,
                     {ras_empty, ras_full, ras_overflow, ras_underflow});
            checks++;
            if (pc_out !== tbl[i].pc) begin errors++;
                $display("FAIL overflow_pc cyc %0d: got %h expected %h", i, pc_out, tbl[i].pc); end
            checks++;
            if ({ras_empty, ras_full, ras_overflow, ras_underflow} !== e.flags) begin errors++;
                $display("FAIL overflow_flags cyc %0d: got %b expected %b", i,
                         {ras_empty, ras_full, ras_overflow, ras_underflow}, e.flags); end
        end
        checks++;
        if (ras_empty !== 1'b1) begin errors++;
            $display("FAIL overflow_drained: ras_empty got %b expected 1", ras_empty); end
    endtask

    task automatic test_back_to_back();
        stim_t tbl [13] = '{
            '{1'b1,1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h0},
            '{1'b0,1'b0,1'b0,1'b1,1'b0, 32'h100, 32'h100},
            '{1'b0,1'b0,1'b0,1'b1,1'b0, 32'h200, 32'h200},
            '{1'b0,1'b0,1'b0,1'b1,1'b0, 32'h300, 32'h300},
            '{1'b0,1'b0,1'b0,1'b1,1'b0, 32'h400, 32'h400},
            '{1'b0,1'b0,1'b0,1'b1,1'b0, 32'h500, 32'h500},
            '{1'b0,1'b0,1'b0,1'b1,1'b1, 32'h600, 32'h600},
            '{1'b0,1'b0,1'b1,1'b0,1'b0, 32'h0,   32'h504},
            '{1'b0,1'b0,1'b1,1'b0,1'b0, 32'h0,   32'h404},
            '{1'b0,1'b0,1'b1,1'b0,1'b0, 32'h0,   32'h304},
            '{1'b0,1'b0,1'b1,1'b0,1'b0, 32'h0,   32'h204},
            '{1'b0,1'b0,1'b1,1'b0,1'b0, 32'h0,   32'h208},
            '{1'b0,1'b0,1'b1,1'b0,1'b0, 32'h0,   32'h20C}};
        exp_t e;
        for (int i = 0; i < 13; i++) begin
            drive_cycle(tbl[i]);
            e = exp_q.pop_front();
            $display("[back_to_back] cyc %0d pc=%h flags=%b", i, pc_out,
                     {ras_empty, ras_full, ras_overflow, ras_underflow});
            checks++;
            if (pc_out !== tbl[i].pc) begin errors++;
                $display("FAIL b2b_pc cyc %0d: got %h expected %h", i, pc_out, tbl[i].pc); end
            checks++;
            if ({ras_empty, ras_full, ras_overflow, ras_underflow} !== e.flags) begin errors++;
                $display("FAIL b2b_flags cyc %0d: got %b expected %b", i,
                         {ras_empty, ras_full, ras_overflow, ras_underflow}, e.flags); end
        end
    endtask

    task automatic test_underflow_priority();
        stim_t tbl [15] = '{
            '{1'b1,1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h0},
            '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h4},
            '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h8},
            '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,   32'hC},
            '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h10},
            '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h14},
            '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h18},
            '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h1C},
            '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h20},
            '{1'b0,1'b0,1'b1,1'b0,1'b0, 32'h0,   32'h24},
            '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h28},
            '{1'b0,1'b0,1'b0,1'b1,1'b0, 32'h600, 32'h600},
            '{1'b0,1'b1,1'b1,1'b0,1'b0, 32'h0,   32'h600},
            '{1'b0,1'b0,1'b1,1'b1,1'b0, 32'h700, 32'h2C},
            '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h30}};
        exp_t e;
        for (int i = 0; i < 15; i++) begin
            drive_cycle(tbl[i]);
            e = exp_q.pop_front();
            $display("[underflow_prio] cyc %0d pc=%h flags=%b", i, pc_out,
                     {ras_empty, ras_full, ras_overflow, ras_underflow});
            checks++;
            if (pc_out !== tbl[i].pc) begin errors++;
                $display("FAIL underflow_prio_pc cyc %0d: got %h expected %h", i, pc_out, tbl[i].pc); end
            checks++;
            if ({ras_empty, ras_full, ras_overflow, ras_underflow} !== e.flags) begin errors++;
                $display("FAIL underflow_prio_flags cyc %0d: got %b expected %b", i,
                         {ras_empty, ras_full, ras_overflow, ras_underflow}, e.flags); end
        end
    endtask

    task automatic test_clr_mid();
        stim_t tbl [5] = '{
            '{1'b1,1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h0},
            '{1'b0,1'b0,1'b0,1'b1,1'b0, 32'h100, 32'h100},
            '{1'b0,1'b0,1'b0,1'b1,1'b0, 32'h200, 32'h200},
            '{1'b1,1'b0,1'b0,1'b1,1'b0, 32'h300, 32'h0},
            '{1'b0,1'b0,1'b1,1'b0,1'b0, 32'h0,   32'h4}};
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            drive_cycle(tbl[i]);
            e = exp_q.pop_front();
            $display("[clr_mid] cyc %0d pc=%h flags=%b", i, pc_out,
                     {ras_empty, ras_full, ras_overflow, ras_underflow});
            checks++;
            if (pc_out !== tbl[i].pc) begin errors++;
                $display("FAIL clr_mid_pc cyc %0d: got %h expected %h", i, pc_out, tbl[i].pc); end
            checks++;
            if ({ras_empty, ras_full, ras_overflow, ras_underflow} !== e.flags) begin errors++;
                $display("FAIL clr_mid_flags cyc %0d: got %b expected %b", i,
                         {ras_empty, ras_full, ras_overflow, ras_underflow}, e.flags); end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] wq[$];
        logic [31:0] exp_pc;
        logic        clr_seq [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        wq.push_back(32'hFFFF_FFFC);
        wq.push_back(32'hFFFF_FFFC);
        wq.push_back(32'h0000_0000);
        wq.push_back(32'h0000_0004);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            clr_w = clr_seq[i];
            @(posedge clk);
            #1;
            exp_pc = wq.pop_front();
            $display("[wrap] cyc %0d pc=%h", i, pc_w);
            checks++;
            if (pc_w !== exp_pc) begin errors++;
                $display("FAIL wrap_pc cyc %0d: got %h expected %h", i, pc_w, exp_pc); end
            checks++;
            if ({empty_w, full_w, ovf_w, unf_w} !== 4'b1000) begin errors++;
                $display("FAIL wrap_flags cyc %0d: got %b expected 1000", i,
                         {empty_w, full_w, ovf_w, unf_w}); end
        end
    endtask

    initial begin
        m_pc = 32'h0;
        test_reset();
        test_branch_stall();
        test_call_ret();
        test_overflow();
        test_back_to_back();
        test_underflow_priority();
        test_clr_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
